// File: rtl/ptw_pte_pkg.sv
// Shared Sv39 PTE types, walk geometry and the PTE classification rule
// used by the page-table walker response path.
package ptw_pte_pkg;

  localparam int PG_LEVELS  = 3;
  localparam int PGIDX_BITS = 9;
  localparam int PPN_W      = 54;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       rsw;
    logic             d;
    logic             a;
    logic             g;
    logic             u;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
  } pte_t;

  typedef enum logic [1:0] {
    PTE_INVALID    = 2'd0,
    PTE_TABLE      = 2'd1,
    PTE_LEAF       = 2'd2,
    PTE_MISALIGNED = 2'd3
  } pte_kind_e;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic             d;
    logic             a;
    logic             g;
    logic             u;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
    logic [1:0]       level;
    pte_kind_e        kind;
  } pte_out_t;

  // A superpage leaf at level L must have its low L*pgidx_bits ppn bits clear.
  function automatic pte_kind_e pte_classify(input pte_t pte, input logic [1:0] level,
                                             input int pg_levels = PG_LEVELS,
                                             input int pgidx_bits = PGIDX_BITS);
    pte_kind_e kind;
    int        align_bits;
    logic      low_set;
    align_bits = int'(level) * pgidx_bits;
    low_set    = 1'b0;
    for (int i = 0; i < PPN_W; i++) begin
      if (i < align_bits && pte.ppn[i]) low_set = 1'b1;
    end
    if (int'(level) >= pg_levels || !pte.v || (pte.w && !pte.r)) begin
      kind = PTE_INVALID;
    end else if (!pte.r && !pte.x) begin
      kind = (level == 2'd0) ? PTE_INVALID : PTE_TABLE;
    end else if (level != 2'd0 && low_set) begin
      kind = PTE_MISALIGNED;
    end else begin
      kind = PTE_LEAF;
    end
    return kind;
  endfunction

endpackage

// File: rtl/ptw_skid_buffer.sv
// Generic 2-entry ready/valid skid buffer (main + skid register) with a
// synchronous flush; in_ready is the registered inverse of skid occupancy.
module ptw_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Handshake: a transfer happens on a side when valid && ready are both high
  // at the rising clock edge; out_data is held stable while out_valid && !out_ready.
  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (main_valid) begin
      if (out_fire) begin
        main_valid <= in_fire;
        if (in_fire) main_data <= in_data;
      end else if (in_fire) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (in_fire) begin
      main_data  <= in_data;
      main_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ptw_pte_unpack.sv
// Registered PTE unpack/classify stage for the page-table walker: splits the
// raw Sv39 word, classifies it, buffers it and counts delivered faults.
module ptw_pte_unpack
  import ptw_pte_pkg::pte_t, ptw_pte_pkg::pte_out_t, ptw_pte_pkg::pte_classify,
         ptw_pte_pkg::PTE_INVALID, ptw_pte_pkg::PTE_MISALIGNED;
#(
  parameter int PG_LEVELS  = 3,
  parameter int PGIDX_BITS = 9,
  parameter int FCNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [63:0]       io_in_data,
  input  logic [1:0]        io_in_level,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [53:0]       io_out_ppn,
  output logic              io_out_d,
  output logic              io_out_a,
  output logic              io_out_g,
  output logic              io_out_u,
  output logic              io_out_x,
  output logic              io_out_w,
  output logic              io_out_r,
  output logic              io_out_v,
  output logic [1:0]        io_out_level,
  output logic [1:0]        io_out_kind,
  output logic [FCNT_W-1:0] io_fault_count
);

  pte_t     pte;
  pte_out_t in_entry;
  pte_out_t out_entry;
  logic     unused_rsw;

  assign pte        = pte_t'(io_in_data);
  assign unused_rsw = ^pte.rsw;

  always_comb begin
    in_entry.ppn   = pte.ppn;
    in_entry.d     = pte.d;
    in_entry.a     = pte.a;
    in_entry.g     = pte.g;
    in_entry.u     = pte.u;
    in_entry.x     = pte.x;
    in_entry.w     = pte.w;
    in_entry.r     = pte.r;
    in_entry.v     = pte.v;
    in_entry.level = io_in_level;
    in_entry.kind  = pte_classify(pte, io_in_level, PG_LEVELS, PGIDX_BITS);
  end

  ptw_skid_buffer #(
    .WIDTH($bits(pte_out_t))
  ) u_skid (
    .clk      (clock),
    .rst      (reset),
    .flush    (io_flush),
    .in_valid (io_in_valid),
    .in_ready (io_in_ready),
    .in_data  (in_entry),
    .out_valid(io_out_valid),
    .out_ready(io_out_ready),
    .out_data (out_entry)
  );

  assign io_out_ppn   = out_entry.ppn;
  assign io_out_d     = out_entry.d;
  assign io_out_a     = out_entry.a;
  assign io_out_g     = out_entry.g;
  assign io_out_u     = out_entry.u;
  assign io_out_x     = out_entry.x;
  assign io_out_w     = out_entry.w;
  assign io_out_r     = out_entry.r;
  assign io_out_v     = out_entry.v;
  assign io_out_level = out_entry.level;
  assign io_out_kind  = out_entry.kind;

  // Deliveries in a flush cycle still count; the counter survives flushes.
  logic fault_fire;
  assign fault_fire = io_out_valid && io_out_ready &&
                      (out_entry.kind == PTE_INVALID || out_entry.kind == PTE_MISALIGNED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_fault_count <= '0;
    end else if (fault_fire && io_fault_count != {FCNT_W{1'b1}}) begin
      io_fault_count <= io_fault_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ptw_pte_unpack.sv
// Self-checking bench for ptw_pte_unpack: directed cases plus random traffic
// against a queue-based reference model of the stage.
module tb_ptw_pte_unpack;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_flush;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_in_data;
  logic [1:0]  io_in_level;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [53:0] io_out_ppn;
  logic        io_out_d, io_out_a, io_out_g, io_out_u;
  logic        io_out_x, io_out_w, io_out_r, io_out_v;
  logic [1:0]  io_out_level;
  logic [1:0]  io_out_kind;
  logic [15:0] io_fault_count;

  logic        s_in_ready, s_out_valid;
  logic [53:0] s_ppn;
  logic        s_d, s_a, s_g, s_u, s_x, s_w, s_r, s_v;
  logic [1:0]  s_level, s_kind;
  logic [1:0]  s_fault_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [65:0] exp_q[$];
  int          exp_cnt;
  int          exp_cnt_s;
  logic [65:0] dut_ent;

  assign dut_ent = {io_out_ppn, io_out_d, io_out_a, io_out_g, io_out_u,
                    io_out_x, io_out_w, io_out_r, io_out_v, io_out_level, io_out_kind};

  always #5 clock = ~clock;

  ptw_pte_unpack u_dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_data(io_in_data), .io_in_level(io_in_level),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_ppn(io_out_ppn), .io_out_d(io_out_d), .io_out_a(io_out_a),
    .io_out_g(io_out_g), .io_out_u(io_out_u), .io_out_x(io_out_x),
    .io_out_w(io_out_w), .io_out_r(io_out_r), .io_out_v(io_out_v),
    .io_out_level(io_out_level), .io_out_kind(io_out_kind),
    .io_fault_count(io_fault_count)
  );

  ptw_pte_unpack #(.FCNT_W(2)) u_dut_small (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(s_in_ready),
    .io_in_data(io_in_data), .io_in_level(io_in_level),
    .io_out_valid(s_out_valid), .io_out_ready(io_out_ready),
    .io_out_ppn(s_ppn), .io_out_d(s_d), .io_out_a(s_a),
    .io_out_g(s_g), .io_out_u(s_u), .io_out_x(s_x),
    .io_out_w(s_w), .io_out_r(s_r), .io_out_v(s_v),
    .io_out_level(s_level), .io_out_kind(s_kind),
    .io_fault_count(s_fault_count)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference classification straight from the Sv39 rules.
  function automatic logic [1:0] ref_kind(input logic [63:0] word, input int lvl);
    logic [63:0] ppn;
    logic        v, r, w, x;
    ppn = {10'd0, word[63:10]};
    v = word[0]; r = word[1]; w = word[2]; x = word[3];
    if (lvl >= 3 || !v || (w && !r)) return 2'd0;
    if (!r && !w && !x) return (lvl == 0) ? 2'd0 : 2'd1;
    if (lvl > 0 && (ppn % (64'd1 << (9 * lvl))) != 0) return 2'd3;
    return 2'd2;
  endfunction

  // Scoreboard: compare at each falling edge, then advance the model by the
  // handshakes that the coming rising edge will perform.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_cnt   = 0;
        exp_cnt_s = 0;
        check_eq("rst_out_valid", io_out_valid, 1'b0);
        check_eq("rst_in_ready", io_in_ready, 1'b1);
        check_eq("rst_fault_count", io_fault_count, 16'd0);
        check_eq("rst_fault_count_small", s_fault_count, 2'd0);
        check_eq("rst_out_fields", dut_ent, 66'd0);
      end else begin
        bit in_fire, out_fire;
        check_eq("out_valid", io_out_valid, exp_q.size() > 0);
        check_eq("in_ready", io_in_ready, exp_q.size() < 2);
        check_eq("fault_count", io_fault_count, (exp_cnt > 65535) ? 65535 : exp_cnt);
        check_eq("fault_count_small", s_fault_count, exp_cnt_s);
        if (exp_q.size() > 0) check_eq("out_entry", dut_ent, exp_q[0]);
        in_fire  = io_in_valid && exp_q.size() < 2;
        out_fire = exp_q.size() > 0 && io_out_ready;
        if (out_fire) begin
          if (exp_q[0][1:0] == 2'd0 || exp_q[0][1:0] == 2'd3) begin
            exp_cnt++;
            if (exp_cnt_s < 3) exp_cnt_s++;
          end
          void'(exp_q.pop_front());
        end
        if (io_flush) exp_q.delete();
        else if (in_fire)
          exp_q.push_back({io_in_data[63:10], io_in_data[7:0], io_in_level,
                           ref_kind(io_in_data, int'(io_in_level))});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] data, input logic [1:0] level);
    bit fired = 0;
    step();
    io_in_valid = 1'b1;
    io_in_data  = data;
    io_in_level = level;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (io_in_ready) begin
        fired = 1;
        break;
      end
    end
    if (!fired) check_eq("send_timeout", 1'b0, 1'b1);
    step();
    io_in_valid = 1'b0;
  endtask

  task automatic send_expect(input logic [63:0] data, input logic [1:0] level, input logic [1:0] kind);
    send(data, level);
    @(negedge clock);
    check_eq("dir_valid", io_out_valid, 1'b1);
    check_eq("dir_kind", io_out_kind, kind);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_seq[5];
    sat_seq = '{1, 2, 3, 3, 3};
    reset        = 1'b1;
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_data   = '0;
    io_in_level  = '0;
    io_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    step();
    reset = 1'b0;

    // Basic classifications.
    send_expect(64'h0000_0000_2000_00CF, 2'd0, 2'd2);
    check_eq("leaf_ppn", io_out_ppn, 54'h80000);
    check_eq("leaf_flags", {io_out_d, io_out_a, io_out_x, io_out_w, io_out_r, io_out_v}, 6'b111111);
    check_eq("leaf_count", io_fault_count, 16'd0);
    send_expect(64'h0000_0000_2000_0001, 2'd2, 2'd1);
    send_expect(64'h0000_0000_2000_0001, 2'd0, 2'd0);
    @(negedge clock);
    check_eq("count_after_invalid", io_fault_count, 16'd1);
    send_expect(64'h0000_0000_0000_140F, 2'd1, 2'd3);
    send_expect(64'h0000_0000_0000_140F, 2'd0, 2'd2);

    // Backpressure: A, B buffered, C stalls until release.
    step();
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_level  = 2'd0;
    io_in_data   = 64'h0000_0000_0000_0C0B;
    step();
    io_in_data   = 64'h0000_0000_0000_100B;
    step();
    io_in_data   = 64'h0000_0000_0000_140B;
    repeat (3) begin
      @(negedge clock);
      check_eq("bp_in_ready", io_in_ready, 1'b0);
      check_eq("bp_out_valid", io_out_valid, 1'b1);
    end
    step();
    io_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (io_in_ready) break;
    end
    step();
    io_in_valid = 1'b0;
    repeat (4) step();

    // Flush with both registers full while input is offered.
    io_out_ready = 1'b0;
    send(64'h0000_0000_0000_0001, 2'd2);
    send(64'h0000_0000_0000_0003, 2'd1);
    io_in_valid = 1'b1;
    io_in_data  = 64'h0000_0000_0000_3C0F;
    io_flush    = 1'b1;
    step();
    io_flush    = 1'b0;
    io_in_valid = 1'b0;
    @(negedge clock);
    check_eq("flush_out_valid", io_out_valid, 1'b0);
    check_eq("flush_in_ready", io_in_ready, 1'b1);

    // Flush with one entry while the input would fire: input is dropped.
    send(64'h0000_0000_0000_0001, 2'd1);
    step();
    io_in_valid = 1'b1;
    io_in_data  = 64'h0000_0000_0000_000F;
    io_flush    = 1'b1;
    step();
    io_flush    = 1'b0;
    io_in_valid = 1'b0;
    @(negedge clock);
    check_eq("flush_drop_valid", io_out_valid, 1'b0);
    io_out_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset while entries are buffered.
    io_out_ready = 1'b0;
    send(64'h0000_0000_0000_0001, 2'd1);
    send(64'h0000_0000_0000_0000, 2'd0);
    step();
    reset = 1'b1;
    #2;
    check_eq("async_rst_valid", io_out_valid, 1'b0);
    check_eq("async_rst_count", io_fault_count, 16'd0);
    repeat (2) @(negedge clock);
    step();
    reset = 1'b0;
    io_out_ready = 1'b1;

    // Saturation of the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      send_expect(64'h0, 2'd0, 2'd0);
      @(negedge clock);
      check_eq("sat_count_small", s_fault_count, sat_seq[i]);
    end

    // Random traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [53:0] ppn;
      step();
      ppn = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) ppn[17:0] = '0;
      io_in_valid  = ($urandom_range(0, 3) != 0);
      io_out_ready = ($urandom_range(0, 3) != 0);
      io_flush     = ($urandom_range(0, 31) == 0);
      io_in_data   = {ppn, 2'($urandom), 8'($urandom)};
      io_in_level  = 2'($urandom_range(0, 3));
    end
    step();
    io_in_valid  = 1'b0;
    io_flush     = 1'b0;
    io_out_ready = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
